// File: rtl/mux4to1_rr_arbiter_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter,
// plus the shared 4:1 mux data lanes that the arbiter's select steers.
interface mux4to1_rr_arbiter_if #(
    parameter int CNT_W = 8
);
    // Handshake: a requester raises req[i] and holds it for as long as it
    // wants the mux; it owns the mux only while gnt[i] (and valid) is high.
    // There is no separate ready: the grant may be withdrawn by slot expiry
    // while req[i] is still high, and dropping req[i] releases it on the next
    // edge. y is meaningful only while valid is high.
    logic [3:0]       req;
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic             valid;
    logic [CNT_W-1:0] slot_cnt;
    logic             dbg_state;  // 0 = IDLE, 1 = GRANT
    logic [3:0]       w;
    logic             y;

    modport master (
        input  req,
        input  w,
        output gnt,
        output sel,
        output valid,
        output slot_cnt,
        output dbg_state,
        output y
    );

    modport slave (
        output req,
        output w,
        input  gnt,
        input  sel,
        input  valid,
        input  slot_cnt,
        input  dbg_state,
        input  y
    );
endinterface

// File: rtl/mux4to1_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux among four requesters; each grant
// is held until released or until SLOT_MAX cycles pass with others waiting.
module mux4to1_rr_arbiter #(
    parameter int SLOT_MAX = 8,
    parameter int CNT_W    = 8
) (
    input logic                    clk,
    input logic                    rst,
    mux4to1_rr_arbiter_if.master   bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] cur;
    logic [1:0] last;

    logic [3:0] others;
    logic [1:0] pick_idle;
    logic [1:0] pick_rel;
    logic [1:0] pick_exp;
    logic       expired;

    // First set bit of mask searching base+1, base+2, base+3, base (mod 4).
    function automatic logic [1:0] pick(input logic [1:0] base, input logic [3:0] mask);
        logic [1:0] idx;
        pick = base;
        for (int k = 4; k >= 1; k--) begin
            idx = base + 2'(k);
            if (mask[idx]) pick = idx;
        end
    endfunction

    always_comb begin
        others    = bus.req & ~(4'b0001 << cur);
        pick_idle = pick(last, bus.req);
        pick_rel  = pick(cur, bus.req);
        pick_exp  = pick(cur, others);
        expired   = (bus.slot_cnt == CNT_W'(SLOT_MAX));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cur          <= 2'd0;
            last         <= 2'd3;
            bus.gnt      <= 4'b0000;
            bus.sel      <= 2'd0;
            bus.valid    <= 1'b0;
            bus.slot_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // sel keeps its previous value while idle
                    if (|bus.req) begin
                        cur          <= pick_idle;
                        bus.gnt      <= 4'b0001 << pick_idle;
                        bus.sel      <= pick_idle;
                        bus.valid    <= 1'b1;
                        bus.slot_cnt <= CNT_W'(1);
                        state        <= GRANT;
                    end
                end
                GRANT: begin
                    if (!bus.req[cur]) begin
                        last <= cur;
                        if (|bus.req) begin
                            cur          <= pick_rel;
                            bus.gnt      <= 4'b0001 << pick_rel;
                            bus.sel      <= pick_rel;
                            bus.slot_cnt <= CNT_W'(1);
                        end else begin
                            bus.gnt      <= 4'b0000;
                            bus.valid    <= 1'b0;
                            bus.slot_cnt <= '0;
                            state        <= IDLE;
                        end
                    end else if (expired) begin
                        // A lone owner simply restarts its slot
                        bus.slot_cnt <= CNT_W'(1);
                        if (|others) begin
                            last    <= cur;
                            cur     <= pick_exp;
                            bus.gnt <= 4'b0001 << pick_exp;
                            bus.sel <= pick_exp;
                        end
                    end else begin
                        bus.slot_cnt <= bus.slot_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign bus.dbg_state = logic'(state);
    assign bus.y         = bus.w[bus.sel];

    a_gnt_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(bus.gnt));
    a_valid_gnt: assert property (@(posedge clk) disable iff (rst)
        bus.valid == (bus.gnt != 4'b0000));
    a_sel_gnt: assert property (@(posedge clk) disable iff (rst)
        bus.valid |-> bus.gnt[bus.sel]);
    a_cnt_max: assert property (@(posedge clk) disable iff (rst)
        bus.slot_cnt <= CNT_W'(SLOT_MAX));

endmodule

// File: doc/mux4to1_rr_arbiter.md
# mux4to1_rr_arbiter

Round-robin arbiter that shares one `mux4to1` instance among four requesters. It drives the mux select `s` and a one-hot grant, and holds each grant until the requester releases it or its time slot expires. It sits directly in front of the `mux4to1` select input. Downstream logic samples mux output `y` only while `valid` is high.

## Interface

Parameters:
- `SLOT_MAX`, default 8: maximum consecutive cycles one grant is held while other requests are pending. Legal range is 1..255.
- `CNT_W`, default 8: slot counter width. It must satisfy `2**CNT_W > SLOT_MAX`.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `req`, input, 4: request vector. `req[i]` belongs to mux input `w[i]`.
- `gnt`, output, 4: registered one-hot grant. All zero when no grant is active.
- `sel`, output, 2: registered mux select, wired to `mux4to1` input `s`. Equals the index of the set `gnt` bit.
- `valid`, output, 1: registered. High exactly when `gnt != 0`.
- `slot_cnt`, output, `CNT_W`: cycles the current grant has been held. Counts from 1 and is 0 when idle.

## Operation

State machine has two states, IDLE and GRANT. Internal state is `cur` (2 b, current owner) and `last` (2 b, previous owner).

Reset (async, takes effect immediately, no clock needed):
- `gnt` = 0, `sel` = 0, `valid` = 0, `slot_cnt` = 0.
- `last` = 3, so requester 0 has highest priority after reset. State = IDLE.

Pick function `pick(base, mask)`:
- Returns the first set bit of `mask` searching `base+1`, `base+2`, `base+3`, `base` (mod 4).

IDLE:
- `req` == 0: stay in IDLE. Outputs hold; `sel` keeps its last value.
- `req` != 0: `cur` = `pick(last, req)`. Set `gnt[cur]`, `sel` = `cur`, `valid` = 1, `slot_cnt` = 1. Go to GRANT.

GRANT, evaluated each edge:
- Release (`req[cur]` == 0):
  - If `req` != 0: regrant in the same edge to `pick(cur, req)`, with `slot_cnt` = 1 and no idle gap.
  - Else: set `last` = `cur`, `gnt` = 0, `valid` = 0, `slot_cnt` = 0, and go to IDLE.
- Expiry (`req[cur]` == 1 and `slot_cnt` == `SLOT_MAX`):
  - Let `others = req & ~(1<<cur)`.
  - If `others` != 0: grant `pick(cur, others)` with `slot_cnt` = 1. `last` is updated to the old `cur`.
  - Else: keep `cur` and restart `slot_cnt` at 1.
- Otherwise: hold the grant and increment `slot_cnt`.

General rules:
- Exactly one of release, expiry or hold applies per edge. Release has priority over expiry.
- `slot_cnt` never exceeds `SLOT_MAX` and never wraps.
- When `SLOT_MAX` = 1 and requests contend, ownership rotates every cycle.

## Timing

- Grant latency: `req` sampled high at edge N (from IDLE) makes `gnt`/`sel`/`valid` update immediately after edge N, i.e. visible during cycle N+1.
- Release latency: `req[cur]` sampled low at edge N removes or moves the grant after edge N.
- Handoff is zero-gap: `valid` stays high across an owner change, and `sel` changes on the same edge as `gnt`.
- `gnt`, `sel` and `valid` are glitch-free registered outputs. `y` of the mux is valid one mux propagation delay after the edge.
- Simultaneous new requests during a grant have no effect until a release or expiry edge.
- Reset asserted mid-grant clears all outputs asynchronously within the same cycle. After reset deassertion, the first grant follows the IDLE rule with `last` = 3.

## Test plan

- Reset mid-operation: `req`=1111 with owner 2, assert `rst` between edges. Outputs are 0 before the next edge. After release, with `req`=1111 held, the first grant goes to `gnt`=0001, `sel`=0.
- Single requester: `req`=0100 sampled at edge N gives `gnt`=0100, `sel`=2, `valid`=1, `slot_cnt`=1 after N. Dropping `req` at edge M gives `gnt`=0, `valid`=0, `slot_cnt`=0 after M.
- Full contention, `SLOT_MAX`=8: `req`=1111 held for 40 cycles. Owners are 0,1,2,3,0, each for exactly 8 cycles. `valid` never drops. `slot_cnt` runs 1..8 per owner.
- Early release handoff: `req`=0011, requester 0 drops after 3 granted cycles. On that edge `gnt`=0010, `sel`=1 and `slot_cnt`=1, with no gap.
- Lone expiry: `req`=0001 held for 20 cycles gives continuous `gnt`=0001, with `slot_cnt` sequence 1..8,1..8,1..4.
- Datapath: drive `w[0..3]` as toggling patterns with periods 20/40/80/160 ns on the `mux4to1` instance. Check `y == w[sel]` on every cycle where `valid`=1, under random `req` for 2000 cycles.
